// File: rtl/dmem_responder.sv
// Single-port data-memory responder: big-endian word array with byte/halfword access and a
// fixed-latency request/response handshake. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_from_proc,
  input  logic [0:31] addr_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  input  logic [0:31] data_to_mem,
  output logic [0:31] data_from_mem,
  output logic        ready_to_proc,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;

  logic [0:31] hold_addr, hold_data;
  logic        hold_write, hold_sext;
  size_t       hold_size;

  logic [0:31] cur_addr, cur_data;
  logic        cur_write, cur_sext;
  size_t       cur_size, in_size;

  logic [AW-1:0] idx;
  logic [0:1]    off, eff_off;
  logic          trap;
  logic          enter_resp;
  logic [0:3]    lanes;
  logic [0:31]   wword, rword, load_result;
  logic [0:7]    rbyte;
  logic [0:15]   rhalf;
  logic [0:31]   load_q;
  logic          unused_addr_bits;

  logic [0:31] mem [DEPTH_WORDS];

  assign in_size = byte_to_mem      ? SZ_BYTE :
                   half_word_to_mem ? SZ_HALF : SZ_WORD;

  // With zero wait states the access commits on the accepting edge, so it must
  // come straight from the ports rather than from the capture registers.
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = addr_to_mem;
      cur_data  = data_to_mem;
      cur_write = write_enable_to_mem;
      cur_sext  = sign_extend_to_mem;
      cur_size  = in_size;
    end else begin
      cur_addr  = hold_addr;
      cur_data  = hold_data;
      cur_write = hold_write;
      cur_sext  = hold_sext;
      cur_size  = hold_size;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (req_from_proc) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            count_next = WAIT_STATES[3:0];
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (count <= 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state_next == RESP);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_write <= 1'b0;
      hold_sext  <= 1'b0;
      hold_size  <= SZ_WORD;
    end else if (state == IDLE && req_from_proc) begin
      hold_addr  <= addr_to_mem;
      hold_data  <= data_to_mem;
      hold_write <= write_enable_to_mem;
      hold_sext  <= sign_extend_to_mem;
      hold_size  <= in_size;
    end
  end

  assign idx              = cur_addr[30-AW +: AW];
  assign off              = cur_addr[30:31];
  assign unused_addr_bits = ^cur_addr[0:29-AW];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign eff_off = off;
  assign trap    = (cur_size == SZ_HALF && off[1]) || (cur_size == SZ_WORD && off != 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          err_q <= 1'b0;
    else if (enter_resp) err_q <= trap;
  end

  assign misalign_err = (state == RESP) && err_q;
`else
  // Misaligned addresses are silently rounded down to the access size.
  always_comb begin
    case (cur_size)
      SZ_BYTE: eff_off = off;
      SZ_HALF: eff_off = {off[0], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Store data is replicated across lanes; the lane mask picks what lands.
  always_comb begin
    lanes = 4'b0000;
    wword = cur_data;
    case (cur_size)
      SZ_BYTE: begin
        lanes[eff_off] = 1'b1;
        wword          = {4{cur_data[24:31]}};
      end
      SZ_HALF: begin
        lanes = eff_off[0] ? 4'b0011 : 4'b1100;
        wword = {2{cur_data[16:31]}};
      end
      default: lanes = 4'b1111;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; contents survive reset and it maps onto RAM.
  always_ff @(posedge clock) begin
    if (enter_resp && cur_write && !trap) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rword = mem[idx];

  always_comb begin
    case (eff_off)
      2'd0:    rbyte = rword[0:7];
      2'd1:    rbyte = rword[8:15];
      2'd2:    rbyte = rword[16:23];
      default: rbyte = rword[24:31];
    endcase
    rhalf = eff_off[0] ? rword[16:31] : rword[0:15];
  end

  always_comb begin
    case (cur_size)
      SZ_BYTE: load_result = {{24{cur_sext & rbyte[0]}}, rbyte};
      SZ_HALF: load_result = {{16{cur_sext & rhalf[0]}}, rhalf};
      default: load_result = rword;
    endcase
    if (trap) load_result = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        load_q <= '0;
    else if (enter_resp && !cur_write) load_q <= load_result;
  end

  assign data_from_mem = load_q;
  assign ready_to_proc = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues the expected response per access,
// a negedge monitor pops and compares data, error flag and latency whenever ready_to_proc fires.
module tb_dmem_responder;

  localparam int WS    = 1;
  localparam int DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_from_proc = 1'b0;
  logic [0:31] addr_to_mem = '0;
  logic        write_enable_to_mem = 1'b0;
  logic        byte_to_mem = 1'b0;
  logic        half_word_to_mem = 1'b0;
  logic        sign_extend_to_mem = 1'b0;
  logic [0:31] data_to_mem = '0;
  logic [0:31] data_from_mem;
  logic        ready_to_proc;
  logic        misalign_err;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] last_load = '0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock               (clock),
    .reset               (reset),
    .req_from_proc       (req_from_proc),
    .addr_to_mem         (addr_to_mem),
    .write_enable_to_mem (write_enable_to_mem),
    .byte_to_mem         (byte_to_mem),
    .half_word_to_mem    (half_word_to_mem),
    .sign_extend_to_mem  (sign_extend_to_mem),
    .data_to_mem         (data_to_mem),
    .data_from_mem       (data_from_mem),
    .ready_to_proc       (ready_to_proc),
    .misalign_err        (misalign_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (ready_to_proc) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("data_from_mem", data_from_mem, e.data);
        check("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
      end
    end else if (misalign_err) begin
      check("err_without_ready", 32'd1, 32'd0);
    end
  end

  // a=address, w=store, b=byte, h=half, s=sign-extend, d=store data, ld=expected load, er=expected error
  task automatic issue(input logic [31:0] a, input logic w, input logic b, input logic h,
                       input logic s, input logic [31:0] d, input logic [31:0] ld, input logic er);
    exp_t e;
    bit   got;
    @(posedge clock);
    #1;
    req_from_proc       = 1'b1;
    addr_to_mem         = a;
    write_enable_to_mem = w;
    byte_to_mem         = b;
    half_word_to_mem    = h;
    sign_extend_to_mem  = s;
    data_to_mem         = d;
    if (!w) last_load = ld;
    e.cyc  = cyc + WS + 1;
    e.data = last_load;
    e.err  = er;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (ready_to_proc) got = 1'b1;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_data", data_from_mem, 32'h0);
    check("reset_ready", {31'd0, ready_to_proc}, 32'd0);
    check("reset_err", {31'd0, misalign_err}, 32'd0);
    reset = 1'b1;

    // addr, w, b, h, s, data, expected load, expected err
    issue(32'h10, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0);
    issue(32'h10, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0);
    issue(32'h13, 0, 1, 0, 1, 32'h0, 32'hFFFFFFEF, 0);
    issue(32'h10, 0, 1, 0, 0, 32'h0, 32'h000000DE, 0);
    issue(32'h10, 0, 0, 1, 1, 32'h0, 32'hFFFFDEAD, 0);
    issue(32'h12, 0, 0, 1, 0, 32'h0, 32'h0000BEEF, 0);
    issue(32'h11, 0, 1, 1, 1, 32'h0, 32'hFFFFFFAD, 0);
    issue(32'h11, 1, 1, 0, 0, 32'h12345655, 32'h0, 0);
    issue(32'h10, 0, 0, 0, 0, 32'h0, 32'hDE55BEEF, 0);
    issue(32'h12, 1, 0, 1, 0, 32'hABCD1234, 32'h0, 0);
    issue(32'h10, 0, 0, 0, 0, 32'h0, 32'hDE551234, 0);
    issue(32'h1010, 1, 0, 0, 0, 32'h12345678, 32'h0, 0);
    issue(32'h10, 0, 0, 0, 0, 32'h0, 32'h12345678, 0);

    // Misaligned word store and halfword load.
    issue(32'h12, 1, 0, 0, 0, 32'hA5A5A5A5, 32'h0, TRAP);
    issue(32'h10, 0, 0, 0, 0, 32'h0, TRAP ? 32'h12345678 : 32'hA5A5A5A5, 0);
    issue(32'h13, 0, 0, 1, 0, 32'h0, TRAP ? 32'h00000000 : 32'h0000A5A5, TRAP);

    // Reset while a store is waiting: it must be dropped and outputs cleared at once.
    issue(32'h20, 1, 0, 0, 0, 32'h11223344, 32'h0, 0);
    issue(32'h20, 0, 0, 0, 0, 32'h0, 32'h11223344, 0);
    @(posedge clock);
    #1;
    req_from_proc       = 1'b1;
    addr_to_mem         = 32'h20;
    write_enable_to_mem = 1'b1;
    byte_to_mem         = 1'b0;
    half_word_to_mem    = 1'b0;
    data_to_mem         = 32'hCAFEF00D;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_data", data_from_mem, 32'h0);
    check("abort_ready", {31'd0, ready_to_proc}, 32'd0);
    check("abort_err", {31'd0, misalign_err}, 32'd0);
    req_from_proc = 1'b0;
    last_load     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("abort_hold_data", data_from_mem, 32'h0);
    reset = 1'b1;
    issue(32'h20, 0, 0, 0, 0, 32'h0, 32'h11223344, 0);

    @(posedge clock);
    #1;
    req_from_proc = 1'b0;
    repeat (4) @(posedge clock);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words; power of two, 16..65536.
REQ-002 Parameter WAIT_STATES, default 1: extra cycles between request acceptance and response; 0..15.
REQ-003 The block SHALL expose these ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_from_proc  in  1  access request; held stable by the processor until ready_to_proc.
- addr_to_mem  in  32  byte address, [0:31], bit 31 LSB.
- write_enable_to_mem  in  1  1 = store, 0 = load.
- byte_to_mem  in  1  byte access; takes precedence over half_word_to_mem.
- half_word_to_mem  in  1  halfword access.
- sign_extend_to_mem  in  1  load sign-extends; 0 = zero-extends.
- data_to_mem  in  32  store data, right-justified for byte and halfword.
- data_from_mem  out  32  load result, right-justified and extended.
- ready_to_proc  out  1  one-cycle completion strobe.
- misalign_err  out  1  one-cycle error strobe, coincident with ready_to_proc.

Function
REQ-004 Storage SHALL be big-endian: byte offset 0 (addr[30:31]=00) maps to bits [0:7] of the word, and halfword offset 0 (addr[30]=0) maps to bits [0:15].
REQ-005 Word index SHALL be the address bits above addr[30:31], taken modulo DEPTH_WORDS (wrap-around, no error).
REQ-006 FSM states SHALL be IDLE, WAIT and RESP.
- IDLE: when req_from_proc=1, capture address, data and controls.
- Next state after capture is WAIT when WAIT_STATES>0, otherwise RESP.
REQ-007 WAIT SHALL load a counter with WAIT_STATES at entry, decrement it each cycle, and move to RESP after exactly WAIT_STATES cycles.
REQ-008 On the edge entering RESP, the block SHALL commit any store to the array and register any load result.
REQ-009 RESP SHALL last exactly one cycle with ready_to_proc=1, then return to IDLE.
- Latency: ready_to_proc is high WAIT_STATES+1 cycles after the accepting cycle.
REQ-010 Requests SHALL be accepted only in IDLE; req_from_proc in WAIT or RESP SHALL be ignored.
- Back-to-back rate: one access per WAIT_STATES+2 cycles.
REQ-011 Loads SHALL return data as follows:
- Word: the full word.
- Halfword: the selected half in bits [16:31]; bits [0:15] are copies of bit 16 when sign_extend_to_mem=1, else zero.
- Byte: the selected byte in bits [24:31], extended the same way from bit 24.
REQ-012 Stores SHALL modify only the addressed lanes:
- Byte: data_to_mem[24:31] written to the selected lane.
- Halfword: data_to_mem[16:31] written to the selected half.
- Word: all 32 bits written.
REQ-013 data_from_mem SHALL hold the last load result until the next load response; stores SHALL NOT change it.
REQ-014 A store and a later load to the same word SHALL return the stored data, since the store commits before the next request can be accepted.

Reset
REQ-015 Asserting reset (reset=0) SHALL immediately force the following, regardless of the current state:
- FSM to IDLE and counter to 0.
- data_from_mem to 0x00000000.
- ready_to_proc and misalign_err to 0.
REQ-016 A store in flight when reset asserts SHALL be dropped; array contents are not cleared by reset.
REQ-017 The first request SHALL be accepted on the first rising edge with reset=1 and req_from_proc=1.

Configuration
REQ-018 Macro DMEM_MISALIGN_TRAP_EN controls misaligned accesses: a halfword with addr[31]=1, or a word with addr[30:31]!=00.
- Defined: the access completes with normal timing; a misaligned store does not modify the array; a misaligned load returns 0x00000000; misalign_err=1 during RESP.
- Undefined: misaligned addresses are forced aligned (low bits cleared as needed); misalign_err is tied to 0.

Verification
REQ-019 WAIT_STATES=1: store word 0xDEADBEEF to 0x00000010, then load word from 0x00000010 -> ready_to_proc 2 cycles after each accept; load returns 0xDEADBEEF.
REQ-020 After REQ-019: byte load, sign-extend, from 0x00000013 -> 0xFFFFFFEF; zero-extend from 0x00000010 -> 0x000000DE; halfword sign-extend from 0x00000010 -> 0xFFFFDEAD.
REQ-021 Byte store 0x00000055 to 0x00000011, then word load from 0x00000010 -> 0xDE55BEEF.
REQ-022 DEPTH_WORDS=1024: store 0x12345678 to 0x00001010, then load from 0x00000010 -> 0x12345678 (wrap-around).
REQ-023 Assert reset during WAIT of a store to 0x00000020 holding 0xCAFEF00D -> outputs 0 immediately, no ready_to_proc; after release, word load from 0x00000020 returns the prior contents.
REQ-024 With DMEM_MISALIGN_TRAP_EN: word store to 0x00000012 -> misalign_err=1 with ready_to_proc and memory unchanged. Without the macro: the same store writes word 0x00000010.
